multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Multi-cycle RV32I control FSM; successor to the single-cycle combinational decoder.
//  Latches each instruction, sequences it through fetch/decode/execute/memory/writeback.
//  Drives the same datapath selects as before, plus PC/IR write enables and memory req/ack handshakes.
//  Full RV32I ALU and branch decode, parametrised ALUSel width, bounded memory wait with trap.
// PARAMETERS
//  ALUSEL_W  4   width of ALUSel; must be >=4
//  MAX_WAIT  15  cycles a req may wait for ack before trap; 0 = wait forever
//  WAIT_W    4   width of wait counter; must hold MAX_WAIT
// PORTS
//  clk       in   1         clock, rising edge
//  rst       in   1         synchronous, active-high reset
//  inst      in   32        instruction from imem; valid when imem_ack=1
//  imem_req  out  1         instruction fetch request
//  imem_ack  in   1         fetch complete; inst valid this cycle
//  dmem_req  out  1         data memory request
//  MemRW     out  1         1=store, 0=load; qualified by dmem_req
//  dmem_ack  in   1         data access complete (load data valid this cycle)
//  BrEq      in   1         rs1==rs2 from branch comparator
//  BrLt      in   1         rs1<rs2, signed/unsigned per BrUn
//  rd/rs1/rs2 out 5 each    fields of latched IR [11:7]/[19:15]/[24:20]
//  immSel    out  3         0=I 1=S 2=B 3=J 4=U
//  ASel      out  1         0=rs1 1=PC;  BSel 1 bit: 0=rs2 1=imm
//  ALUSel    out  ALUSEL_W  0 add,1 sub,2 sll,3 slt,4 sltu,5 xor,6 srl,7 sra,8 or,9 and,10 passB
//  BrUn      out  1         unsigned compare (bltu/bgeu only)
//  WBSel     out  2         0=mem 1=alu 2=pc+4
//  RegWEn    out  1         register file write enable
//  pcsel     out  1         0=pc+4 1=alu result
//  pc_we     out  1         PC register update strobe
//  illegal   out  1         sticky trap flag
// BEHAVIOUR
//  IR: 32-bit register; loads inst when state=FETCH and imem_ack=1. Reset value 0.
//  States: FETCH, DECODE, EXEC, MEM, WB, TRAP. Reset -> FETCH; all outputs 0 except as listed per state.
//  FETCH: imem_req=1. Leaves on imem_ack only (load IR -> DECODE).
//  DECODE (1 cycle): illegal opcode/funct -> TRAP; else -> EXEC.
//  EXEC: datapath selects driven from IR.
//   R/I-arith -> WB. Load/store -> MEM.
//   Branch: pcsel = taken, pc_we=1 -> FETCH.
//    beq BrEq; bne ~BrEq; blt BrLt; bge ~BrLt; bltu/bgeu same with BrUn=1.
//   JAL/JALR/LUI/AUIPC -> WB.
//  MEM: dmem_req=1, MemRW=1 for store. Stays until dmem_ack.
//   On ack: load -> WB; store -> pc_we=1, pcsel=0, FETCH.
//  WB (1 cycle): RegWEn=1 unless rd==0, pc_we=1.
//   pcsel=1 for JAL/JALR, else 0. -> FETCH.
//  Selects, all held stable from EXEC through WB:
//   ASel: 1 for B/JAL/AUIPC.
//   BSel: 1 for all except R-type.
//   LUI: ALUSel=passB. SRAI/SRA: funct7=0100000.
//  Wait counter: cleared on entry to FETCH/MEM; increments each cycle req=1 and ack=0.
//   If MAX_WAIT!=0 and counter reaches MAX_WAIT -> TRAP.
//   Ack in the same cycle as reaching MAX_WAIT wins (no trap).
//  TRAP: illegal=1; all req/we outputs 0; held until rst.
//  Spurious ack (no req asserted) is ignored.
//  rst mid-operation: next cycle FETCH, IR=0, illegal=0; any in-flight ack is discarded.
//  CPI: ALU 4+fetch wait, load 5+waits, store 4+waits, branch 3+fetch wait.
// TESTING
//  addi x1,x0,5 (0x00500093), ack at once -> req,DECODE,EXEC,WB; WB: RegWEn=1 ALUSel=0 BSel=1 WBSel=1 pc_we=1
//  sub (0x40208133) -> EXEC ALUSel=1 BSel=0; sra funct7=0x20 -> ALUSel=7; srl -> 6
//  bltu, BrLt=1 -> BrUn=1, pcsel=1, pc_we=1 in EXEC; bge, BrLt=1 -> pcsel=0; no RegWEn
//  lw, dmem_ack after 3 cycles -> dmem_req high 4 cycles, MemRW=0; WB: WBSel=0 RegWEn=1
//  sw -> MemRW=1, RegWEn never 1
//  opcode 0x7F -> illegal=1 after DECODE, req/we all 0, stays until rst, then imem_req=1
//  MAX_WAIT=15, imem_ack never -> TRAP after 15 req cycles
//  ack on cycle 15 -> no trap
//  rst during MEM -> FETCH next cycle, dmem_req=0
//  JAL rd=0 -> RegWEn=0, pcsel=1

Source files
------------

// File: rtl/multicycle_control_if.sv
// Control <-> datapath/memory bundle for the multi-cycle RV32I controller.
// The controller takes the master side; the datapath and memories take the slave side.
interface multicycle_control_if #(
  parameter int ALUSEL_W = 4
);
  logic [31:0]         inst;
  logic                imem_req;
  logic                imem_ack;
  logic                dmem_req;
  logic                MemRW;
  logic                dmem_ack;
  logic                BrEq;
  logic                BrLt;
  logic [4:0]          rd;
  logic [4:0]          rs1;
  logic [4:0]          rs2;
  logic [2:0]          immSel;
  logic                ASel;
  logic                BSel;
  logic [ALUSEL_W-1:0] ALUSel;
  logic                BrUn;
  logic [1:0]          WBSel;
  logic                RegWEn;
  logic                pcsel;
  logic                pc_we;
  logic                illegal;

  modport master (
    input  inst, imem_ack, dmem_ack, BrEq, BrLt,
    output imem_req, dmem_req, MemRW, rd, rs1, rs2, immSel, ASel, BSel,
           ALUSel, BrUn, WBSel, RegWEn, pcsel, pc_we, illegal
  );

  modport slave (
    output inst, imem_ack, dmem_ack, BrEq, BrLt,
    input  imem_req, dmem_req, MemRW, rd, rs1, rs2, immSel, ASel, BSel,
           ALUSel, BrUn, WBSel, RegWEn, pcsel, pc_we, illegal
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: latches each instruction and sequences it through
// fetch/decode/execute/memory/writeback, trapping on illegal encodings or memory timeouts.
module multicycle_control #(
  parameter int ALUSEL_W = 4,
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  multicycle_control_if.master bus
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [WAIT_W:0] LP_MAX_WAIT = (WAIT_W+1)'(MAX_WAIT);

  typedef enum logic [2:0] {
    ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_TRAP
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [31:0]       r_ir;
  logic [WAIT_W-1:0] r_wait;

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic        w_is_reg, w_is_imm, w_is_load, w_is_store, w_is_branch;
  logic        w_is_jal, w_is_jalr, w_is_lui, w_is_auipc, w_legal;
  logic [3:0]  w_alu_op;
  logic [2:0]  w_imm_sel;
  logic [1:0]  w_wb_sel;
  logic        w_asel, w_bsel, w_brun, w_taken;
  logic [WAIT_W:0] w_wait_inc;
  logic        w_timeout, w_pending;
  logic        w_drive, w_imem_req, w_dmem_req, w_memrw;
  logic        w_regwen, w_pcsel, w_pc_we;

  assign w_opcode = r_ir[6:0];
  assign w_funct3 = r_ir[14:12];
  assign w_funct7 = r_ir[31:25];

  // Instruction class and legality; only the funct7 values RV32I defines are accepted.
  always_comb begin
    w_is_reg    = 1'b0;
    w_is_imm    = 1'b0;
    w_is_load   = 1'b0;
    w_is_store  = 1'b0;
    w_is_branch = 1'b0;
    w_is_jal    = 1'b0;
    w_is_jalr   = 1'b0;
    w_is_lui    = 1'b0;
    w_is_auipc  = 1'b0;
    w_legal     = 1'b0;
    case (w_opcode)
      OP_REG: begin
        w_is_reg = 1'b1;
        w_legal  = (w_funct7 == 7'b0000000) ||
                   ((w_funct7 == 7'b0100000) && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)));
      end
      OP_IMM: begin
        w_is_imm = 1'b1;
        if (w_funct3 == 3'b001)      w_legal = (w_funct7 == 7'b0000000);
        else if (w_funct3 == 3'b101) w_legal = (w_funct7 == 7'b0000000) || (w_funct7 == 7'b0100000);
        else                         w_legal = 1'b1;
      end
      OP_LOAD: begin
        w_is_load = 1'b1;
        w_legal   = (w_funct3 != 3'b011) && (w_funct3 != 3'b110) && (w_funct3 != 3'b111);
      end
      OP_STORE: begin
        w_is_store = 1'b1;
        w_legal    = (w_funct3 <= 3'b010);
      end
      OP_BRANCH: begin
        w_is_branch = 1'b1;
        w_legal     = (w_funct3[2:1] != 2'b01);
      end
      OP_JAL:   begin w_is_jal   = 1'b1; w_legal = 1'b1; end
      OP_JALR:  begin w_is_jalr  = 1'b1; w_legal = (w_funct3 == 3'b000); end
      OP_LUI:   begin w_is_lui   = 1'b1; w_legal = 1'b1; end
      OP_AUIPC: begin w_is_auipc = 1'b1; w_legal = 1'b1; end
      default:  w_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_alu_op = 4'd0;
    if (w_is_reg || w_is_imm) begin
      case (w_funct3)
        3'b000:  w_alu_op = (w_is_reg && w_funct7[5]) ? 4'd1 : 4'd0;
        3'b001:  w_alu_op = 4'd2;
        3'b010:  w_alu_op = 4'd3;
        3'b011:  w_alu_op = 4'd4;
        3'b100:  w_alu_op = 4'd5;
        3'b101:  w_alu_op = w_funct7[5] ? 4'd7 : 4'd6;
        3'b110:  w_alu_op = 4'd8;
        default: w_alu_op = 4'd9;
      endcase
    end else if (w_is_lui) begin
      w_alu_op = 4'd10;
    end

    if (w_is_store)                   w_imm_sel = 3'd1;
    else if (w_is_branch)             w_imm_sel = 3'd2;
    else if (w_is_jal)                w_imm_sel = 3'd3;
    else if (w_is_lui || w_is_auipc)  w_imm_sel = 3'd4;
    else                              w_imm_sel = 3'd0;

    if (w_is_load)                    w_wb_sel = 2'd0;
    else if (w_is_jal || w_is_jalr)   w_wb_sel = 2'd2;
    else                              w_wb_sel = 2'd1;

    w_asel = w_is_branch || w_is_jal || w_is_auipc;
    w_bsel = !w_is_reg;
    w_brun = w_is_branch && (w_funct3[2:1] == 2'b11);
    // funct3[0] inverts the sense: bne/bge/bgeu are the complements of beq/blt/bltu.
    w_taken = (w_funct3[2] ? bus.BrLt : bus.BrEq) ^ w_funct3[0];
  end

  assign w_wait_inc = {1'b0, r_wait} + {{WAIT_W{1'b0}}, 1'b1};
  assign w_timeout  = (MAX_WAIT != 0) && (w_wait_inc == LP_MAX_WAIT);
  assign w_pending  = ((r_state == ST_FETCH) && !bus.imem_ack) ||
                      ((r_state == ST_MEM)   && !bus.dmem_ack);

  // Acks are only looked at in the state that issued the matching request,
  // and an ack always wins over a timeout reached in the same cycle.
  always_comb begin
    w_next     = r_state;
    w_drive    = 1'b0;
    w_imem_req = 1'b0;
    w_dmem_req = 1'b0;
    w_memrw    = 1'b0;
    w_regwen   = 1'b0;
    w_pcsel    = 1'b0;
    w_pc_we    = 1'b0;
    case (r_state)
      ST_FETCH: begin
        w_imem_req = 1'b1;
        if (bus.imem_ack)  w_next = ST_DECODE;
        else if (w_timeout) w_next = ST_TRAP;
      end
      ST_DECODE: w_next = w_legal ? ST_EXEC : ST_TRAP;
      ST_EXEC: begin
        w_drive = 1'b1;
        if (w_is_branch) begin
          w_pcsel = w_taken;
          w_pc_we = 1'b1;
          w_next  = ST_FETCH;
        end else if (w_is_load || w_is_store) begin
          w_next = ST_MEM;
        end else begin
          w_next = ST_WB;
        end
      end
      ST_MEM: begin
        w_drive    = 1'b1;
        w_dmem_req = 1'b1;
        w_memrw    = w_is_store;
        if (bus.dmem_ack) begin
          if (w_is_store) begin
            w_pc_we = 1'b1;
            w_next  = ST_FETCH;
          end else begin
            w_next  = ST_WB;
          end
        end else if (w_timeout) begin
          w_next = ST_TRAP;
        end
      end
      ST_WB: begin
        w_drive  = 1'b1;
        w_regwen = (r_ir[11:7] != 5'd0);
        w_pc_we  = 1'b1;
        w_pcsel  = w_is_jal || w_is_jalr;
        w_next   = ST_FETCH;
      end
      ST_TRAP: w_next = ST_TRAP;
      default: w_next = ST_FETCH;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_FETCH;
      r_ir    <= 32'd0;
      r_wait  <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == ST_FETCH) && bus.imem_ack) r_ir <= bus.inst;
      if (r_state != w_next)                     r_wait <= '0;
      else if (w_pending && (r_wait != '1))      r_wait <= r_wait + WAIT_W'(1);
    end
  end

  assign bus.imem_req = w_imem_req;
  assign bus.dmem_req = w_dmem_req;
  assign bus.MemRW    = w_memrw;
  assign bus.rd       = r_ir[11:7];
  assign bus.rs1      = r_ir[19:15];
  assign bus.rs2      = r_ir[24:20];
  assign bus.immSel   = w_drive ? w_imm_sel : 3'd0;
  assign bus.ASel     = w_drive && w_asel;
  assign bus.BSel     = w_drive && w_bsel;
  assign bus.ALUSel   = w_drive ? ALUSEL_W'(w_alu_op) : '0;
  assign bus.BrUn     = w_drive && w_brun;
  assign bus.WBSel    = w_drive ? w_wb_sel : 2'd0;
  assign bus.RegWEn   = w_regwen;
  assign bus.pcsel    = w_pcsel;
  assign bus.pc_we    = w_pc_we;
  assign bus.illegal  = (r_state == ST_TRAP);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control with hand-computed expectations.
module tb_multicycle_control;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  multicycle_control_if #(.ALUSEL_W(4)) bus();

  multicycle_control #(.ALUSEL_W(4), .MAX_WAIT(15), .WAIT_W(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // Inputs change 2 time units after a rising edge; checks happen 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.inst = 32'd0; bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
    bus.BrEq = 1'b0;  bus.BrLt = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Fetch with immediate ack, then pass DECODE; returns positioned in the EXEC cycle.
  task automatic issue(input logic [31:0] instr);
    bus.inst = instr;
    bus.imem_ack = 1'b1;
    tick();
    bus.imem_ack = 1'b0;
    bus.inst = 32'd0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("[TB] FAIL reset_imem_req: got %0b expected 1", bus.imem_req); end
    checks++; if (bus.illegal !== 1'b0) begin errors++; $display("[TB] FAIL reset_illegal: got %0b expected 0", bus.illegal); end
    checks++; if (bus.dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_dmem_req: got %0b expected 0", bus.dmem_req); end
    checks++; if (bus.pc_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_pc_we: got %0b expected 0", bus.pc_we); end
    checks++; if (bus.RegWEn !== 1'b0) begin errors++; $display("[TB] FAIL reset_regwen: got %0b expected 0", bus.RegWEn); end
    checks++; if (bus.rd !== 5'd0) begin errors++; $display("[TB] FAIL reset_rd: got %0d expected 0", bus.rd); end
  endtask

  task automatic test_addi();
    do_reset();
    bus.inst = 32'h00500093; bus.imem_ack = 1'b1;
    #1;
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("[TB] FAIL addi_fetch_req: got %0b expected 1", bus.imem_req); end
    tick(); bus.imem_ack = 1'b0; bus.inst = 32'd0; #1;
    checks++; if (bus.imem_req !== 1'b0 || bus.pc_we !== 1'b0) begin errors++; $display("[TB] FAIL addi_decode: got req=%0b pc_we=%0b expected 0 0", bus.imem_req, bus.pc_we); end
    tick(); #1;
    checks++; if (bus.rd !== 5'd1 || bus.RegWEn !== 1'b0) begin errors++; $display("[TB] FAIL addi_exec: got rd=%0d RegWEn=%0b expected 1 0", bus.rd, bus.RegWEn); end
    tick(); #1;
    checks++; if (bus.RegWEn !== 1'b1) begin errors++; $display("[TB] FAIL addi_wb_regwen: got %0b expected 1", bus.RegWEn); end
    checks++; if (bus.ALUSel !== 4'd0 || bus.BSel !== 1'b1) begin errors++; $display("[TB] FAIL addi_wb_alu: got ALUSel=%0d BSel=%0b expected 0 1", bus.ALUSel, bus.BSel); end
    checks++; if (bus.WBSel !== 2'd1 || bus.pc_we !== 1'b1 || bus.pcsel !== 1'b0) begin errors++; $display("[TB] FAIL addi_wb_pc: got WBSel=%0d pc_we=%0b pcsel=%0b expected 1 1 0", bus.WBSel, bus.pc_we, bus.pcsel); end
    tick(); #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.RegWEn !== 1'b0) begin errors++; $display("[TB] FAIL addi_refetch: got req=%0b RegWEn=%0b expected 1 0", bus.imem_req, bus.RegWEn); end
  endtask

  task automatic test_alu_decode();
    logic [31:0] insts [8];
    logic [3:0]  alu   [8];
    logic        bsel  [8];
    logic        asel  [8];
    logic [2:0]  imm   [8];
    // sub, sra, srl, srai, slti, and, lui, auipc
    insts = '{32'h40208133, 32'h4020D1B3, 32'h0020D1B3, 32'h4030D093,
              32'h00102093, 32'h003170B3, 32'h123452B7, 32'h00001097};
    alu   = '{4'd1, 4'd7, 4'd6, 4'd7, 4'd3, 4'd9, 4'd10, 4'd0};
    bsel  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    asel  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    imm   = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd4, 3'd4};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      issue(insts[i]);
      #1;
      checks++; if (bus.ALUSel !== alu[i]) begin errors++; $display("[TB] FAIL alu_sel[%0d]: got %0d expected %0d", i, bus.ALUSel, alu[i]); end
      checks++; if (bus.BSel !== bsel[i] || bus.ASel !== asel[i]) begin errors++; $display("[TB] FAIL alu_ab_sel[%0d]: got A=%0b B=%0b expected A=%0b B=%0b", i, bus.ASel, bus.BSel, asel[i], bsel[i]); end
      checks++; if (bus.immSel !== imm[i] || bus.WBSel !== 2'd1) begin errors++; $display("[TB] FAIL alu_imm_wb[%0d]: got imm=%0d wb=%0d expected imm=%0d wb=1", i, bus.immSel, bus.WBSel, imm[i]); end
      tick(); #1;
      checks++; if (bus.RegWEn !== 1'b1 || bus.ALUSel !== alu[i]) begin errors++; $display("[TB] FAIL alu_wb[%0d]: got RegWEn=%0b ALUSel=%0d expected 1 %0d", i, bus.RegWEn, bus.ALUSel, alu[i]); end
      tick();
    end
  endtask

  task automatic test_branch();
    logic [31:0] insts [6];
    logic        eq    [6];
    logic        lt    [6];
    logic        taken [6];
    logic        un    [6];
    // beq, bne, blt, bge, bltu, bgeu
    insts = '{32'h00208063, 32'h00209063, 32'h0020C063, 32'h0020D063, 32'h0020E063, 32'h0020F063};
    eq    = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    lt    = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    taken = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    un    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      issue(insts[i]);
      bus.BrEq = eq[i]; bus.BrLt = lt[i];
      #1;
      checks++; if (bus.pcsel !== taken[i]) begin errors++; $display("[TB] FAIL br_pcsel[%0d]: got %0b expected %0b", i, bus.pcsel, taken[i]); end
      checks++; if (bus.BrUn !== un[i]) begin errors++; $display("[TB] FAIL br_brun[%0d]: got %0b expected %0b", i, bus.BrUn, un[i]); end
      checks++; if (bus.pc_we !== 1'b1 || bus.RegWEn !== 1'b0) begin errors++; $display("[TB] FAIL br_we[%0d]: got pc_we=%0b RegWEn=%0b expected 1 0", i, bus.pc_we, bus.RegWEn); end
      checks++; if (bus.ASel !== 1'b1 || bus.immSel !== 3'd2) begin errors++; $display("[TB] FAIL br_sel[%0d]: got ASel=%0b imm=%0d expected 1 2", i, bus.ASel, bus.immSel); end
      tick();
      bus.BrEq = 1'b0; bus.BrLt = 1'b0;
      #1;
      checks++; if (bus.imem_req !== 1'b1 || bus.pc_we !== 1'b0) begin errors++; $display("[TB] FAIL br_refetch[%0d]: got req=%0b pc_we=%0b expected 1 0", i, bus.imem_req, bus.pc_we); end
    end
  endtask

  task automatic test_load();
    do_reset();
    issue(32'h00012083);
    #1;
    checks++; if (bus.dmem_req !== 1'b0 || bus.WBSel !== 2'd0 || bus.BSel !== 1'b1) begin errors++; $display("[TB] FAIL lw_exec: got req=%0b wb=%0d B=%0b expected 0 0 1", bus.dmem_req, bus.WBSel, bus.BSel); end
    tick();
    for (int i = 0; i < 4; i++) begin
      bus.dmem_ack = (i == 3);
      #1;
      checks++; if (bus.dmem_req !== 1'b1 || bus.MemRW !== 1'b0) begin errors++; $display("[TB] FAIL lw_mem[%0d]: got req=%0b MemRW=%0b expected 1 0", i, bus.dmem_req, bus.MemRW); end
      tick();
    end
    bus.dmem_ack = 1'b0;
    #1;
    checks++; if (bus.dmem_req !== 1'b0 || bus.RegWEn !== 1'b1) begin errors++; $display("[TB] FAIL lw_wb_req: got req=%0b RegWEn=%0b expected 0 1", bus.dmem_req, bus.RegWEn); end
    checks++; if (bus.WBSel !== 2'd0 || bus.pc_we !== 1'b1 || bus.pcsel !== 1'b0) begin errors++; $display("[TB] FAIL lw_wb_sel: got wb=%0d pc_we=%0b pcsel=%0b expected 0 1 0", bus.WBSel, bus.pc_we, bus.pcsel); end
    tick(); #1;
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("[TB] FAIL lw_refetch: got %0b expected 1", bus.imem_req); end
  endtask

  task automatic test_store();
    do_reset();
    issue(32'h0020A023);
    #1;
    checks++; if (bus.immSel !== 3'd1 || bus.dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL sw_exec: got imm=%0d req=%0b expected 1 0", bus.immSel, bus.dmem_req); end
    tick(); #1;
    checks++; if (bus.dmem_req !== 1'b1 || bus.MemRW !== 1'b1 || bus.pc_we !== 1'b0) begin errors++; $display("[TB] FAIL sw_mem_wait: got req=%0b MemRW=%0b pc_we=%0b expected 1 1 0", bus.dmem_req, bus.MemRW, bus.pc_we); end
    tick();
    bus.dmem_ack = 1'b1;
    #1;
    checks++; if (bus.pc_we !== 1'b1 || bus.pcsel !== 1'b0 || bus.RegWEn !== 1'b0) begin errors++; $display("[TB] FAIL sw_mem_ack: got pc_we=%0b pcsel=%0b RegWEn=%0b expected 1 0 0", bus.pc_we, bus.pcsel, bus.RegWEn); end
    tick();
    bus.dmem_ack = 1'b0;
    #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.RegWEn !== 1'b0) begin errors++; $display("[TB] FAIL sw_refetch: got req=%0b RegWEn=%0b expected 1 0", bus.imem_req, bus.RegWEn); end
  endtask

  task automatic test_jump();
    do_reset();
    issue(32'h0080006F);
    #1;
    checks++; if (bus.ASel !== 1'b1 || bus.immSel !== 3'd3 || bus.WBSel !== 2'd2) begin errors++; $display("[TB] FAIL jal_exec: got A=%0b imm=%0d wb=%0d expected 1 3 2", bus.ASel, bus.immSel, bus.WBSel); end
    tick(); #1;
    checks++; if (bus.RegWEn !== 1'b0 || bus.pcsel !== 1'b1 || bus.pc_we !== 1'b1) begin errors++; $display("[TB] FAIL jal_x0_wb: got RegWEn=%0b pcsel=%0b pc_we=%0b expected 0 1 1", bus.RegWEn, bus.pcsel, bus.pc_we); end
    tick();
    issue(32'h000100E7);
    tick(); #1;
    checks++; if (bus.RegWEn !== 1'b1 || bus.pcsel !== 1'b1 || bus.WBSel !== 2'd2 || bus.ASel !== 1'b0) begin errors++; $display("[TB] FAIL jalr_wb: got RegWEn=%0b pcsel=%0b wb=%0d A=%0b expected 1 1 2 0", bus.RegWEn, bus.pcsel, bus.WBSel, bus.ASel); end
    tick();
  endtask

  task automatic test_illegal();
    do_reset();
    bus.inst = 32'h0000007F; bus.imem_ack = 1'b1;
    tick();
    bus.imem_ack = 1'b0;
    #1;
    checks++; if (bus.illegal !== 1'b0) begin errors++; $display("[TB] FAIL ill_decode: got %0b expected 0", bus.illegal); end
    tick(); #1;
    checks++; if (bus.illegal !== 1'b1) begin errors++; $display("[TB] FAIL ill_trap: got %0b expected 1", bus.illegal); end
    checks++; if (bus.imem_req !== 1'b0 || bus.dmem_req !== 1'b0 || bus.pc_we !== 1'b0 || bus.RegWEn !== 1'b0) begin errors++; $display("[TB] FAIL ill_quiet: got ireq=%0b dreq=%0b pc_we=%0b RegWEn=%0b expected 0 0 0 0", bus.imem_req, bus.dmem_req, bus.pc_we, bus.RegWEn); end
    bus.imem_ack = 1'b1; bus.dmem_ack = 1'b1;
    tick(); tick(); tick();
    bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
    #1;
    checks++; if (bus.illegal !== 1'b1 || bus.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL ill_sticky: got illegal=%0b req=%0b expected 1 0", bus.illegal, bus.imem_req); end
    do_reset();
    #1;
    checks++; if (bus.illegal !== 1'b0 || bus.imem_req !== 1'b1) begin errors++; $display("[TB] FAIL ill_cleared: got illegal=%0b req=%0b expected 0 1", bus.illegal, bus.imem_req); end
  endtask

  task automatic test_timeout();
    int reqs = 0;
    do_reset();
    for (int i = 0; i < 15; i++) begin
      #1;
      if (bus.imem_req === 1'b1 && bus.illegal === 1'b0) reqs++;
      tick();
    end
    checks++; if (reqs != 15) begin errors++; $display("[TB] FAIL timeout_req_cycles: got %0d expected 15", reqs); end
    #1;
    checks++; if (bus.illegal !== 1'b1 || bus.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL timeout_trap: got illegal=%0b req=%0b expected 1 0", bus.illegal, bus.imem_req); end
  endtask

  task automatic test_ack_at_limit();
    do_reset();
    for (int i = 0; i < 14; i++) tick();
    bus.inst = 32'h00500093; bus.imem_ack = 1'b1;
    tick();
    bus.imem_ack = 1'b0; bus.inst = 32'd0;
    #1;
    checks++; if (bus.illegal !== 1'b0 || bus.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL limit_ack_wins: got illegal=%0b req=%0b expected 0 0", bus.illegal, bus.imem_req); end
    tick(); #1;
    checks++; if (bus.rd !== 5'd1 || bus.BSel !== 1'b1) begin errors++; $display("[TB] FAIL limit_exec: got rd=%0d B=%0b expected 1 1", bus.rd, bus.BSel); end
    tick(); tick();
  endtask

  task automatic test_reset_mid_mem();
    do_reset();
    issue(32'h00012083);
    tick(); #1;
    checks++; if (bus.dmem_req !== 1'b1) begin errors++; $display("[TB] FAIL rstmem_in_mem: got %0b expected 1", bus.dmem_req); end
    rst = 1'b1; bus.dmem_ack = 1'b1;
    tick();
    rst = 1'b0; bus.dmem_ack = 1'b0;
    #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.dmem_req !== 1'b0 || bus.RegWEn !== 1'b0) begin errors++; $display("[TB] FAIL rstmem_fetch: got ireq=%0b dreq=%0b RegWEn=%0b expected 1 0 0", bus.imem_req, bus.dmem_req, bus.RegWEn); end
    checks++; if (bus.rd !== 5'd0) begin errors++; $display("[TB] FAIL rstmem_ir_clear: got rd=%0d expected 0", bus.rd); end
    tick(); #1;
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("[TB] FAIL rstmem_stay_fetch: got %0b expected 1", bus.imem_req); end
  endtask

  task automatic test_spurious_ack();
    do_reset();
    bus.dmem_ack = 1'b1;
    tick();
    bus.dmem_ack = 1'b0;
    #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL spurious_dmem_ack: got ireq=%0b dreq=%0b expected 1 0", bus.imem_req, bus.dmem_req); end
  endtask

  initial begin
    rst = 1'b1;
    bus.inst = 32'd0; bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
    bus.BrEq = 1'b0;  bus.BrLt = 1'b0;
    test_reset();
    test_addi();
    test_alu_decode();
    test_branch();
    test_load();
    test_store();
    test_jump();
    test_illegal();
    test_timeout();
    test_ack_at_limit();
    test_reset_mid_mem();
    test_spurious_ack();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
